// File: rtl/axi4l_wr_arbiter.sv
// Two-requester round-robin AXI4-Lite write sequencer with one transaction outstanding.
// Optional watchdog: define AXIL_WR_TIMEOUT_EN to abort stalled transactions with SLVERR.
module axi4l_wr_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [1:0]              req_valid,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_data,
  output logic [1:0]              req_ready,
  output logic [1:0]              req_done,
  output logic [1:0]              req_resp,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY
);
  // state     | meaning
  // IDLE      | no transaction; a pending request is granted here
  // ADDR_DATA | AW and W presented, handshakes tracked independently
  // RESP      | BREADY high, waiting for BVALID
  // DONE      | one-cycle req_done/req_resp to the granted requester
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR_DATA = 2'd1, RESP = 2'd2, DONE = 2'd3} state_e;

  state_e                state_q, state_d;
  logic                  ptr_q, gnt_q;
  logic                  awvalid_q, wvalid_q, bready_q;
  logic                  aw_done_q, w_done_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            resp_q;
  logic                  grant_req, gnt_idx;
  logic                  aw_hs, w_hs, aw_ok, w_ok, b_hs, to_hit;

  // Reset is folded in so the combinational grant cannot pulse while held in reset.
  assign grant_req = ARESETn && (state_q == IDLE) && (|req_valid);
  assign gnt_idx   = req_valid[ptr_q] ? ptr_q : ~ptr_q;
  assign aw_hs     = awvalid_q && AWREADY;
  assign w_hs      = wvalid_q && WREADY;
  assign aw_ok     = aw_done_q || aw_hs;
  assign w_ok      = w_done_q || w_hs;
  assign b_hs      = bready_q && BVALID;

`ifdef AXIL_WR_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)
      cnt_q <= '0;
    else if (state_q == ADDR_DATA || state_q == RESP)
      cnt_q <= cnt_q + 1'b1;
    else
      cnt_q <= '0;
  end

  assign to_hit = (state_q == ADDR_DATA || state_q == RESP) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (grant_req) state_d = ADDR_DATA;
      ADDR_DATA: if (to_hit) state_d = DONE;
                 else if (aw_ok && w_ok) state_d = RESP;
      RESP:      if (b_hs || to_hit) state_d = DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ptr_q     <= 1'b0;
      gnt_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      resp_q    <= 2'b00;
    end else begin
      case (state_q)
        IDLE: if (grant_req) begin
          gnt_q     <= gnt_idx;
          awaddr_q  <= gnt_idx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
          wdata_q   <= gnt_idx ? req_data[2*DATA_WIDTH-1:DATA_WIDTH] : req_data[DATA_WIDTH-1:0];
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end
        ADDR_DATA: if (to_hit) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          resp_q    <= 2'b10;
        end else begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            aw_done_q <= 1'b1;
          end
          if (w_hs) begin
            wvalid_q <= 1'b0;
            w_done_q <= 1'b1;
          end
          if (aw_ok && w_ok) bready_q <= 1'b1;
        end
        // A genuine response in the watchdog's last cycle is reported as-is.
        RESP: if (b_hs) begin
          resp_q   <= BRESP;
          bready_q <= 1'b0;
        end else if (to_hit) begin
          resp_q   <= 2'b10;
          bready_q <= 1'b0;
        end
        DONE: ptr_q <= ~gnt_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    req_ready = 2'b00;
    req_done  = 2'b00;
    req_resp  = 2'b00;
    busy      = (state_q != IDLE);
    if (grant_req) begin
      req_ready[gnt_idx] = 1'b1;
      busy               = 1'b1;
    end
    if (state_q == DONE) begin
      req_done[gnt_q] = 1'b1;
      req_resp        = resp_q;
    end
  end

  assign AWADDR  = awaddr_q;
  assign WDATA   = wdata_q;
  assign AWVALID = awvalid_q;
  assign WVALID  = wvalid_q;
  assign BREADY  = bready_q;

endmodule
